seq_alu: RTL and testbench



---
 rtl/seq_alu_pkg.sv | 42 ++++
 rtl/seq_alu_iter_muldiv.sv | 81 ++++++++
 rtl/seq_alu.sv | 137 +++++++++++++
 tb/tb_seq_alu.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/seq_alu_pkg.sv
// seq_alu_pkg: shared types and constants for the sequential ALU.
//   alu_sel_e : 4-bit operation code (0..10 single-cycle, 11..14 iterative, 15 undefined)
//   state_e   : control states of seq_alu
//   DIV0_QUOT : quotient returned for a divide by zero (truncated to W at use)
package seq_alu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_AND   = 4'd2,
    ALU_OR    = 4'd3,
    ALU_XOR   = 4'd4,
    ALU_SLT   = 4'd5,
    ALU_SLTU  = 4'd6,
    ALU_SLL   = 4'd7,
    ALU_SRL   = 4'd8,
    ALU_SRA   = 4'd9,
    ALU_COPY1 = 4'd10,
    ALU_MUL   = 4'd11,
    ALU_MULHU = 4'd12,
    ALU_DIVU  = 4'd13,
    ALU_REMU  = 4'd14
  } alu_sel_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [63:0] DIV0_QUOT = '1;

  // Operation codes handled by the multi-cycle multiply/divide unit.
  function automatic logic is_iter(input logic [3:0] sel);
    return sel inside {ALU_MUL, ALU_MULHU, ALU_DIVU, ALU_REMU};
  endfunction

  function automatic logic is_div(input logic [3:0] sel);
    return sel inside {ALU_DIVU, ALU_REMU};
  endfunction

endpackage

// File: rtl/seq_alu_iter_muldiv.sv
// iter_muldiv: one-bit-per-cycle unsigned multiplier / restoring divider.
//   clk, rst  : clock, async active-high reset
//   start     : load operands (first step is taken on the same edge)
//   div_mode  : 0 = shift-add multiply, 1 = restoring divide
//   a, b      : multiplicand/dividend and multiplier/divisor
//   acc       : 2W accumulator; mul -> {hi, lo} product, div -> {rem, quot}
//   done      : one-cycle pulse after the final (W-th) step
//   div_zero  : divisor of the current operation was zero
module iter_muldiv #(
  parameter int unsigned W = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           div_mode,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic [2*W-1:0] acc,
  output logic           done,
  output logic           div_zero
);

  localparam int unsigned SHW = $clog2(W);
  localparam int unsigned CW  = SHW + 1;

  logic [CW-1:0] cnt;
  logic          run;
  logic          mode;
  logic [W-1:0]  b_q;

  // One multiply or divide iteration on the accumulator.
  function automatic logic [2*W-1:0] md_step(input logic [2*W-1:0] cur,
                                             input logic [W-1:0]   d,
                                             input logic           div);
    logic [W:0] sum;
    logic [W:0] part;
    logic [W-1:0] rem;
    if (div) begin
      // Shift the next dividend bit into the partial remainder and try a subtract.
      part = {cur[2*W-1:W], cur[W-1]};
      if (part >= {1'b0, d}) begin
        rem = W'(part - {1'b0, d});
        return {rem, cur[W-2:0], 1'b1};
      end
      return {part[W-1:0], cur[W-2:0], 1'b0};
    end
    // Conditional add into the high half keeps the carry, then shift right.
    sum = {1'b0, cur[2*W-1:W]} + (cur[0] ? {1'b0, d} : {(W+1){1'b0}});
    return {sum, cur[W-1:1]};
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc      <= '0;
      cnt      <= '0;
      run      <= 1'b0;
      mode     <= 1'b0;
      b_q      <= '0;
      done     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        acc      <= md_step({{W{1'b0}}, a}, b, div_mode);
        b_q      <= b;
        mode     <= div_mode;
        div_zero <= (b == '0);
        cnt      <= CW'(1);
        run      <= 1'b1;
      end else if (run) begin
        acc <= md_step(acc, b_q, mode);
        cnt <= cnt + CW'(1);
        if (cnt == CW'(W - 1)) begin
          run  <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/seq_alu.sv
// seq_alu: handshaked ALU with registered result and iterative mul/div.
//   clk, rst             : clock, async active-high reset
//   in_valid / in_ready  : operand handshake (accepted only in IDLE)
//   op1, op2, alu_sel    : operands and operation code
//   out_valid / out_ready: result handshake (held in DONE until taken)
//   result               : registered result, kept until the next completion
//   busy                 : high while an iterative operation is in flight
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] op1,
  input  logic [W-1:0] op2,
  input  logic [3:0]   alu_sel,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic         busy
);

  localparam int unsigned SHW = $clog2(W);

  state_e         state;
  alu_sel_e       it_sel;
  logic [W-1:0]   simple_c;
  logic [W-1:0]   iter_c;
  logic [SHW-1:0] shamt_c;
  logic           accept_c;
  logic           start_c;
  logic [2*W-1:0] md_acc;
  logic           md_done;
  logic           md_div_zero;

  assign shamt_c  = op2[SHW-1:0];
  assign accept_c = (state == ST_IDLE) && in_valid && in_ready;
  assign start_c  = accept_c && is_iter(alu_sel);

  // Single-cycle datapath; undefined codes produce zero.
  always_comb begin
    simple_c = '0;
    case (alu_sel)
      ALU_ADD:   simple_c = op1 + op2;
      ALU_SUB:   simple_c = op1 - op2;
      ALU_AND:   simple_c = op1 & op2;
      ALU_OR:    simple_c = op1 | op2;
      ALU_XOR:   simple_c = op1 ^ op2;
      ALU_SLT:   simple_c = {{(W-1){1'b0}}, ($signed(op1) < $signed(op2))};
      ALU_SLTU:  simple_c = {{(W-1){1'b0}}, (op1 < op2)};
      ALU_SLL:   simple_c = op1 << shamt_c;
      ALU_SRL:   simple_c = op1 >> shamt_c;
      ALU_SRA:   simple_c = W'($signed(op1) >>> shamt_c);
      ALU_COPY1: simple_c = op1;
      default:   simple_c = '0;
    endcase
  end

  // Select the requested half of the iterative accumulator.
  always_comb begin
    iter_c = '0;
    case (it_sel)
      ALU_MUL:   iter_c = md_acc[W-1:0];
      ALU_MULHU: iter_c = md_acc[2*W-1:W];
      ALU_DIVU:  iter_c = md_div_zero ? W'(DIV0_QUOT) : md_acc[W-1:0];
      ALU_REMU:  iter_c = md_acc[2*W-1:W];
      default:   iter_c = '0;
    endcase
  end

  iter_muldiv #(.W(W)) u_iter_muldiv (
    .clk      (clk),
    .rst      (rst),
    .start    (start_c),
    .div_mode (is_div(alu_sel)),
    .a        (op1),
    .b        (op2),
    .acc      (md_acc),
    .done     (md_done),
    .div_zero (md_div_zero)
  );

  // Control FSM with registered handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      it_sel    <= ALU_ADD;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      result    <= '0;
      busy      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          in_ready <= 1'b1;
          if (accept_c) begin
            in_ready <= 1'b0;
            if (is_iter(alu_sel)) begin
              it_sel <= alu_sel_e'(alu_sel);
              busy   <= 1'b1;
              state  <= ST_BUSY;
            end else begin
              result    <= simple_c;
              out_valid <= 1'b1;
              state     <= ST_DONE;
            end
          end
        end
        ST_BUSY: begin
          if (md_done) begin
            result    <= iter_c;
            out_valid <= 1'b1;
            busy      <= 1'b0;
            state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: begin
          state     <= ST_IDLE;
          in_ready  <= 1'b0;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: randomized and directed checks of seq_alu (W=32) against a
// behavioural arithmetic model.
module tb_seq_alu;

  localparam int unsigned W = 32;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] op1;
  logic [W-1:0] op2;
  logic [3:0]   alu_sel;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         busy;

  int n_checks = 0;
  int n_pass   = 0;

  seq_alu #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op1       (op1),
    .op2       (op2),
    .alu_sel   (alu_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
  endtask

  function automatic logic iter_op(input logic [3:0] sel);
    return (sel >= 4'd11) && (sel <= 4'd14);
  endfunction

  // Reference behaviour from plain arithmetic on wide integers.
  function automatic logic [W-1:0] model(input logic [3:0] sel, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    longint unsigned p;
    int sh;
    logic [W-1:0] r;
    sh = int'(b % W);
    p  = longint'(a) * longint'(b);
    case (sel)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd4:  return a ^ b;
      4'd5:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd6:  return (a < b) ? 32'd1 : 32'd0;
      4'd7:  return a << sh;
      4'd8:  return a >> sh;
      4'd9: begin
        r = a >> sh;
        if (a[W-1]) r = r | ~({W{1'b1}} >> sh);
        return r;
      end
      4'd10: return a;
      4'd11: return p[31:0];
      4'd12: return p[63:32];
      4'd13: return (b == 0) ? {W{1'b1}} : a / b;
      4'd14: return (b == 0) ? a : a % b;
      default: return '0;
    endcase
  endfunction

  // Issue one operation, measure latency/busy, apply bp cycles of backpressure.
  task automatic do_op(input string tag, input logic [3:0] sel, input logic [W-1:0] a,
                       input logic [W-1:0] b, input int bp);
    logic [W-1:0] exp;
    int lat;
    int bcnt;
    int g;
    exp = model(sel, a, b);
    g = 0;
    @(negedge clk);
    while (!in_ready && g < 200) begin
      @(negedge clk);
      g++;
    end
    check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    alu_sel  = sel;
    op1      = a;
    op2      = b;
    @(posedge clk);
    #1;
    // Disturb inputs after the accept edge: they must not matter any more.
    in_valid = 1'b0;
    op1      = $urandom;
    op2      = $urandom;
    alu_sel  = 4'($urandom);
    lat  = 0;
    bcnt = 0;
    do begin
      @(negedge clk);
      lat++;
      if (busy) bcnt++;
    end while (!out_valid && lat < 200);
    check({tag, "_latency"}, 64'(lat), iter_op(sel) ? 64'(W + 1) : 64'd1);
    check({tag, "_busy_cycles"}, 64'(bcnt), iter_op(sel) ? 64'(W) : 64'd0);
    check({tag, "_result"}, 64'(result), 64'(exp));
    for (int i = 0; i < bp; i++) begin
      in_valid = 1'b1;
      alu_sel  = 4'd0;
      @(negedge clk);
      check({tag, "_bp_result"}, 64'(result), 64'(exp));
      check({tag, "_bp_valid"}, 64'(out_valid), 64'd1);
      check({tag, "_bp_in_ready"}, 64'(in_ready), 64'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_valid_drop"}, 64'(out_valid), 64'd0);
    check({tag, "_idle_ready"}, 64'(in_ready), 64'd1);
    check({tag, "_result_held"}, 64'(result), 64'(exp));
  endtask

  initial begin
    logic [3:0]   s;
    logic [W-1:0] a;
    logic [W-1:0] b;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    op1       = '0;
    op2       = '0;
    alu_sel   = '0;

    repeat (3) @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_release_in_ready", 64'(in_ready), 64'd1);

    do_op("add_wrap", 4'd0, 32'hFFFF_FFFF, 32'h0000_0001, 0);
    do_op("sra_shamt", 4'd9, 32'h8000_0000, 32'h0000_0024, 0);
    do_op("slt_neg", 4'd5, 32'hFFFF_FFFF, 32'h0000_0001, 0);
    do_op("sltu", 4'd6, 32'hFFFF_FFFF, 32'h0000_0001, 0);
    do_op("undef15", 4'd15, 32'h1234_5678, 32'h9ABC_DEF0, 0);
    do_op("mul_lo", 4'd11, 32'h0001_0000, 32'h0001_0000, 0);
    do_op("mul_hi", 4'd12, 32'h0001_0000, 32'h0001_0000, 0);
    do_op("divu", 4'd13, 32'd100, 32'd7, 0);
    do_op("remu", 4'd14, 32'd100, 32'd7, 0);
    do_op("divu_zero", 4'd13, 32'd5, 32'd0, 0);
    do_op("remu_zero", 4'd14, 32'd5, 32'd0, 0);
    do_op("divu_max", 4'd13, 32'hFFFF_FFFF, 32'd1, 0);
    do_op("bp_simple", 4'd1, 32'd10, 32'd20, 5);
    do_op("bp_iter", 4'd12, 32'hDEAD_BEEF, 32'hCAFE_F00D, 5);

    // Abort a divide partway through with reset.
    @(negedge clk);
    in_valid = 1'b1;
    alu_sel  = 4'd13;
    op1      = 32'd100;
    op2      = 32'd7;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_out_valid", 64'(out_valid), 64'd0);
    check("abort_result", 64'(result), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    do_op("add_after_rst", 4'd0, 32'd2, 32'd3, 0);

    for (int i = 0; i < 40; i++) begin
      s = 4'($urandom_range(0, 15));
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(0, 9));
      if ($urandom_range(0, 5) == 0) a = 32'($urandom_range(0, 300));
      do_op($sformatf("rnd%0d_op%0d", i, s), s, a, b, $urandom_range(0, 2));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
